// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for a radix-2 FFT: loads one frame of samples, steps the
// butterfly stages with one-hot enables, then drains results in bit-reversed order.
module fft_frame_sequencer #(
    parameter int LOG2N        = 5,
    parameter int STAGE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr,
    output logic [LOG2N-1:0] stage_en,
    output logic [3:0]       stage_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] rd_addr,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam logic [LOG2N-1:0] IDX_LAST   = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0] IDX_ZERO   = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] IDX_ONE    = LOG2N'(1);
    localparam logic [CW-1:0]    CYC_LAST   = CW'(STAGE_CYCLES - 1);
    localparam logic [CW-1:0]    CYC_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]    CYC_ONE    = CW'(1);
    localparam logic [3:0]       STAGE_LAST = 4'(LOG2N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [LOG2N-1:0]  r_idx;
    logic [3:0]        r_stage;
    logic [CW-1:0]     r_cyc;
    logic              r_done;

    state_t            w_state_nxt;
    logic [LOG2N-1:0]  w_idx_nxt;
    logic [3:0]        w_stage_nxt;
    logic [CW-1:0]     w_cyc_nxt;
    logic              w_done_nxt;

    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = {LOG2N{1'b0}};
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // State register with synchronous active-low reset; abandons any frame in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_idx   <= IDX_ZERO;
            r_stage <= 4'd0;
            r_cyc   <= CYC_ZERO;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_stage <= w_stage_nxt;
            r_cyc   <= w_cyc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: sample count shared by LOAD and UNLOAD, stage/cycle count in COMPUTE.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_stage_nxt = r_stage;
        w_cyc_nxt   = r_cyc;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = IDX_ZERO;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_idx_nxt = r_idx + IDX_ONE;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_COMPUTE;
                        w_stage_nxt = 4'd1;
                        w_cyc_nxt   = CYC_ZERO;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            S_COMPUTE: begin
                if (r_cyc == CYC_LAST) begin
                    w_cyc_nxt = CYC_ZERO;
                    if (r_stage == STAGE_LAST) begin
                        w_state_nxt = S_UNLOAD;
                        w_idx_nxt   = IDX_ZERO;
                        w_stage_nxt = 4'd0;
                    end else begin
                        w_stage_nxt = r_stage + 4'd1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CYC_ONE;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    w_idx_nxt = r_idx + IDX_ONE;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_UNLOAD;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = IDX_ZERO;
                w_stage_nxt = 4'd0;
                w_cyc_nxt   = CYC_ZERO;
            end
        endcase
    end

    // Output decode from registered state; wr_en alone also looks at in_valid.
    always_comb begin
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = IDX_ZERO;
        stage_en  = {LOG2N{1'b0}};
        stage_sel = 4'd0;
        out_valid = 1'b0;
        rd_addr   = IDX_ZERO;
        out_last  = 1'b0;
        busy      = (r_state != S_IDLE);
        done      = r_done;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                wr_addr  = r_idx;
            end
            S_COMPUTE: begin
                stage_sel = r_stage;
                for (int k = 0; k < LOG2N; k++) begin
                    stage_en[k] = (r_stage == 4'(k + 1));
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                rd_addr   = bit_reverse(r_idx);
                out_last  = (r_idx == IDX_LAST);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
